icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache.
- Implements the icache side of the ICache/Fetch interface: it consumes fetch_e_ and fetch_pc, and produces ic_inst and ic_stall.
- Hits return the instruction combinationally in the same cycle.
- Misses stall fetch and refill one full line from the memory side through a request/grant plus beat handshake. A blocking refill FSM handles this.

---
 rtl/icache_dm.sv | 140 ++++++++++++++
 tb/tb_icache_dm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with blocking line refill
module icache_dm #(
    parameter int ADDR       = 32,
    parameter int INST       = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            fetch_e_,
    input  logic [ADDR-1:0] fetch_pc,
    output logic [INST-1:0] ic_inst,
    output logic            ic_stall,
    input  logic            flush_,
    output logic            mem_req_,
    output logic [ADDR-1:0] mem_addr,
    input  logic            mem_gnt_,
    input  logic            mem_rvalid_,
    input  logic [INST-1:0] mem_rdata
);

    localparam int OFS = $clog2(LINE_WORDS) + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR - IDX - OFS;
    localparam int CW  = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t          state_q, state_d;
    logic [ADDR-1:0] miss_addr_q, miss_addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            abort_q, abort_d;
    logic [SETS-1:0] valid_q, valid_d;

    logic [TAG-1:0]  tag_q  [SETS];
    logic [INST-1:0] data_q [SETS][LINE_WORDS];

    logic [IDX-1:0]  fetch_idx;
    logic [CW-1:0]   fetch_word;
    logic [TAG-1:0]  fetch_tag;
    logic [IDX-1:0]  miss_idx;
    logic [TAG-1:0]  miss_tag;
    logic            hit;
    logic            beat_we;
    logic            tag_we;
    logic            unused_pc_lsbs;

    assign fetch_idx      = fetch_pc[OFS+IDX-1:OFS];
    assign fetch_word     = fetch_pc[OFS-1:2];
    assign fetch_tag      = fetch_pc[ADDR-1:OFS+IDX];
    assign miss_idx       = miss_addr_q[OFS+IDX-1:OFS];
    assign miss_tag       = miss_addr_q[ADDR-1:OFS+IDX];
    assign unused_pc_lsbs = ^fetch_pc[1:0];

    assign hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign ic_stall = (state_q != IDLE) | (!fetch_e_ & !hit);
    assign ic_inst  = (state_q == IDLE && !fetch_e_ && hit) ? data_q[fetch_idx][fetch_word] : '0;
    assign mem_req_ = (state_q != REQ);
    assign mem_addr = (state_q == REQ) ? miss_addr_q : '0;

    // Refill FSM next state, flush handling and storage write enables
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        valid_d     = valid_q;
        beat_we     = 1'b0;
        tag_we      = 1'b0;
        if (!flush_) begin
            valid_d = '0;
        end
        case (state_q)
            IDLE: begin
                if (!fetch_e_ && !hit) begin
                    miss_addr_d = {fetch_pc[ADDR-1:OFS], {OFS{1'b0}}};
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (!flush_) begin
                    abort_d = 1'b1;
                end
                if (!mem_gnt_) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!flush_) begin
                    abort_d = 1'b1;
                end
                if (!mem_rvalid_) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        tag_we = 1'b1;
                        // A flush landing on the last beat also keeps the line invalid
                        if (!abort_q && flush_) begin
                            valid_d[miss_idx] = 1'b1;
                        end
                        abort_d = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; asynchronous reset also drops an in-progress refill
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data arrays carry no reset so they can map onto plain RAM
    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_q[miss_idx][cnt_q] <= mem_rdata;
        end
        if (tag_we) begin
            tag_q[miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - scoreboard bench for icache_dm with a behavioural line memory
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset_;
    logic        fetch_e_;
    logic [31:0] fetch_pc;
    logic [31:0] ic_inst;
    logic        ic_stall;
    logic        flush_;
    logic        mem_req_;
    logic [31:0] mem_addr;
    logic        mem_gnt_;
    logic        mem_rvalid_;
    logic [31:0] mem_rdata;

    icache_dm dut (
        .clk        (clk),
        .reset_     (reset_),
        .fetch_e_   (fetch_e_),
        .fetch_pc   (fetch_pc),
        .ic_inst    (ic_inst),
        .ic_stall   (ic_stall),
        .flush_     (flush_),
        .mem_req_   (mem_req_),
        .mem_addr   (mem_addr),
        .mem_gnt_   (mem_gnt_),
        .mem_rvalid_(mem_rvalid_),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    int          gnt_delay;
    int          beat_gap;
    int          m_state;
    int          m_wait;
    int          m_gap;
    int          m_beat;
    int          m_req_cycles;
    int          m_beats_total;
    logic [31:0] m_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000010) return 32'hA0 + {30'd0, a[3:2]};
        return {a[15:0], 16'h5A00};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: grant after gnt_delay cycles, then 4 beats spaced by beat_gap idle cycles
    initial begin
        mem_gnt_      = 1'b1;
        mem_rvalid_   = 1'b1;
        mem_rdata     = '0;
        m_state       = 0;
        m_wait        = 0;
        m_gap         = 0;
        m_beat        = 0;
        m_req_cycles  = 0;
        m_beats_total = 0;
        m_addr        = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt_    = 1'b1;
            mem_rvalid_ = 1'b1;
            mem_rdata   = '0;
            if (!reset_) begin
                m_state = 0;
            end else begin
                if (!mem_req_) m_req_cycles++;
                if (m_state == 0 && !mem_req_) begin
                    m_state = 1;
                    m_wait  = gnt_delay;
                    m_addr  = mem_addr;
                end
                if (m_state == 1) begin
                    if (m_wait == 0) begin
                        mem_gnt_ = 1'b0;
                        m_state  = 2;
                        m_beat   = 0;
                        m_gap    = 0;
                    end else begin
                        m_wait--;
                    end
                end else if (m_state == 2) begin
                    if (m_gap == 0) begin
                        mem_rvalid_ = 1'b0;
                        mem_rdata   = mem_word(m_addr + 32'(4 * m_beat));
                        m_beat++;
                        m_beats_total++;
                        m_gap = beat_gap;
                        if (m_beat == 4) m_state = 0;
                    end else begin
                        m_gap--;
                    end
                end
            end
        end
    end

    // Starts at posedge+1; counts stalled cycles, then pops the expected instruction
    task automatic do_fetch(input logic [31:0] pc, input int exp_stall, input string tag);
        int n;
        exp_q.push_back(mem_word(pc));
        fetch_pc = pc;
        fetch_e_ = 1'b0;
        n = 0;
        @(negedge clk);
        while (ic_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        check_eq({tag, "_inst"}, ic_inst, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0;
        int b0;
        int n;
        reset_   = 1'b0;
        fetch_e_ = 1'b1;
        fetch_pc = '0;
        flush_   = 1'b1;
        gnt_delay = 0;
        beat_gap  = 0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_stall", {31'd0, ic_stall}, 32'd0);
        check_eq("rst_inst", ic_inst, 32'd0);
        check_eq("rst_req", {31'd0, mem_req_}, 32'd1);
        check_eq("rst_addr", mem_addr, 32'd0);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        // Disabled fetch
        r0 = m_req_cycles;
        for (int i = 0; i < 4; i++) begin
            fetch_pc = $urandom & 32'hFFFF_FFFC;
            fetch_e_ = 1'b1;
            @(negedge clk);
            check_eq("dis_stall", {31'd0, ic_stall}, 32'd0);
            check_eq("dis_inst", ic_inst, 32'd0);
            @(posedge clk);
            #1;
        end
        check_eq("dis_noreq", 32'(m_req_cycles - r0), 32'd0);

        // Cold miss
        r0 = m_req_cycles;
        do_fetch(32'h100, 6, "cold");
        check_eq("cold_addr", m_addr, 32'h100);
        check_eq("cold_req_cycles", 32'(m_req_cycles - r0), 32'd1);

        // Hit sweep
        r0 = m_req_cycles;
        do_fetch(32'h104, 0, "hit1");
        do_fetch(32'h108, 0, "hit2");
        do_fetch(32'h10C, 0, "hit3");
        check_eq("hit_noreq", 32'(m_req_cycles - r0), 32'd0);

        // Conflict with slow memory
        gnt_delay = 3;
        beat_gap  = 1;
        r0 = m_req_cycles;
        do_fetch(32'h500, 12, "conflict");
        check_eq("conflict_addr", m_addr, 32'h500);
        check_eq("conflict_req_cycles", 32'(m_req_cycles - r0), 32'd4);
        do_fetch(32'h508, 0, "conflict_hit");
        gnt_delay = 0;
        beat_gap  = 0;
        do_fetch(32'h100, 6, "refetch");

        // Idle flush: same-cycle lookup still hits, next one misses
        exp_q.push_back(mem_word(32'h100));
        fetch_pc = 32'h100;
        fetch_e_ = 1'b0;
        flush_   = 1'b0;
        @(negedge clk);
        check_eq("iflush_stall", {31'd0, ic_stall}, 32'd0);
        check_eq("iflush_inst", ic_inst, exp_q.pop_front());
        @(posedge clk);
        #1;
        flush_   = 1'b1;
        fetch_e_ = 1'b1;
        do_fetch(32'h100, 6, "iflush_miss");

        // Flush on beat 2 of a refill, fetch dropped before completion
        b0 = m_beats_total;
        fetch_pc = 32'h200;
        fetch_e_ = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        flush_ = 1'b0;
        @(posedge clk);
        #1;
        flush_   = 1'b1;
        fetch_e_ = 1'b1;
        n = 0;
        @(negedge clk);
        while (ic_stall && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("mflush_drain_cycles", 32'(n), 32'd1);
        check_eq("mflush_beats", 32'(m_beats_total - b0), 32'd4);
        @(posedge clk);
        #1;
        do_fetch(32'h200, 6, "mflush_refetch");
        do_fetch(32'h100, 6, "mflush_other");

        // Reset after beat 1 of a refill
        flush_ = 1'b0;
        @(posedge clk);
        #1;
        flush_   = 1'b1;
        fetch_pc = 32'h100;
        fetch_e_ = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2;
        reset_   = 1'b0;
        fetch_e_ = 1'b1;
        #1;
        check_eq("mrst_req", {31'd0, mem_req_}, 32'd1);
        check_eq("mrst_stall", {31'd0, ic_stall}, 32'd0);
        check_eq("mrst_inst", ic_inst, 32'd0);
        check_eq("mrst_addr", mem_addr, 32'd0);
        @(posedge clk);
        #2;
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        do_fetch(32'h100, 6, "mrst_miss");
        do_fetch(32'h10C, 0, "mrst_hit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
